pid_core: RTL and testbench

- Pipelined, fixed-point PID controller for the laser loop.
- Sits directly downstream of the measurement-source 2:1 select stage and consumes the selected measurement sample each time one is valid.
- Computes error = setpoint − measurement, then P, clamped I and D terms, and emits a saturated signed control word.
- Fully pipelined: throughput 1 sample/clock, no backpressure.

---
 rtl/pid_core.sv | 135 +++++++++++++
 tb/tb_pid_core.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_core.sv
// Pipelined fixed-point PID controller: input register, error, P/I/D terms, then
// sum/shift/saturate. One sample per clock, out_valid three edges after acceptance.
module pid_core #(
   parameter int DATA_W = 16,
   parameter int GAIN_W = 16,
   parameter int FRAC_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              clear_int,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] meas,
   input  logic [DATA_W-1:0] setpoint,
   input  logic [GAIN_W-1:0] kp,
   input  logic [GAIN_W-1:0] ki,
   input  logic [GAIN_W-1:0] kd,
   output logic              out_valid,
   output logic [DATA_W-1:0] ctrl_out,
   output logic              sat_hi,
   output logic              sat_lo,
   output logic              int_clamped
);

   localparam int EW  = DATA_W + 1;
   localparam int DFW = DATA_W + 2;
   localparam int GW  = GAIN_W + 1;
   localparam int PW  = GW + EW;
   localparam int DPW = GW + DFW;
   localparam int IW  = DATA_W + FRAC_W;
   localparam int IA  = ((PW > IW) ? PW : IW) + 1;
   localparam int SW  = ((DPW > IW) ? DPW : IW) + 2;

   localparam logic signed [IW-1:0]     I_MAX = {1'b0, {(IW-1){1'b1}}};
   localparam logic signed [IW-1:0]     I_MIN = {1'b1, {(IW-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] O_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] O_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   // Returns {hit_hi, hit_lo, value}.
   function automatic logic [IW+1:0] clamp_int(input logic signed [IA-1:0] x);
      if (x > IA'(I_MAX)) return {2'b10, I_MAX};
      if (x < IA'(I_MIN)) return {2'b01, I_MIN};
      return {2'b00, x[IW-1:0]};
   endfunction

   // Floor by FRAC_W, then clip to the output range; returns {hi, lo, value}.
   function automatic logic [DATA_W+1:0] sat_out(input logic signed [SW-1:0] s);
      logic signed [SW-1:0] q;
      q = s >>> FRAC_W;
      if (q > SW'(O_MAX)) return {2'b10, O_MAX};
      if (q < SW'(O_MIN)) return {2'b01, O_MIN};
      return {2'b00, q[DATA_W-1:0]};
   endfunction

   logic                     vld_p0, vld_p1, vld_p2;
   logic signed [DATA_W-1:0] meas_p0, sp_p0;
   logic signed [EW-1:0]     e_p1;
   logic signed [PW-1:0]     p_p2;
   logic signed [IW-1:0]     i_p2;
   logic signed [DPW-1:0]    d_p2;

   logic signed [IW-1:0]     integ;
   logic signed [EW-1:0]     e_prev;
   logic                     hist;

   logic signed [PW-1:0]     ki_term;
   logic signed [IA-1:0]     i_sum;
   logic [IW+1:0]            i_cl;
   logic signed [IW-1:0]     i_new;
   logic signed [DFW-1:0]    de;
   logic signed [DPW-1:0]    d_raw;
   logic signed [SW-1:0]     sum;
   logic [DATA_W+1:0]        o_sat;

   always_comb begin
      ki_term = PW'($signed({1'b0, ki})) * PW'(e_p1);
      i_sum   = IA'(integ) + IA'(ki_term);
      i_cl    = clamp_int(i_sum);
      i_new   = i_cl[IW-1:0];
      de      = DFW'(e_p1) - DFW'(e_prev);
      d_raw   = DPW'($signed({1'b0, kd})) * DPW'(de);
      sum     = SW'(p_p2) + SW'(i_p2) + SW'(d_p2);
      o_sat   = sat_out(sum);
   end

   // Control, loop state and held outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0      <= 1'b0;
         vld_p1      <= 1'b0;
         vld_p2      <= 1'b0;
         out_valid   <= 1'b0;
         integ       <= '0;
         e_prev      <= '0;
         hist        <= 1'b0;
         int_clamped <= 1'b0;
         ctrl_out    <= '0;
         sat_hi      <= 1'b0;
         sat_lo      <= 1'b0;
      end else begin
         vld_p0    <= in_valid & enable;
         vld_p1    <= vld_p0;
         vld_p2    <= vld_p1;
         out_valid <= vld_p2;
         // clear wins over a sample sitting in the term stage
         if (clear_int) begin
            integ       <= '0;
            e_prev      <= '0;
            hist        <= 1'b0;
            int_clamped <= 1'b0;
         end else if (vld_p1) begin
            integ       <= i_new;
            e_prev      <= e_p1;
            hist        <= 1'b1;
            int_clamped <= |i_cl[IW+1:IW];
         end
         if (vld_p2) begin
            ctrl_out <= o_sat[DATA_W-1:0];
            sat_hi   <= o_sat[DATA_W+1];
            sat_lo   <= o_sat[DATA_W];
         end
      end
   end

   // Datapath: p0 input capture, p1 error, p2 P/I/D terms
   always_ff @(posedge clk) begin
      meas_p0 <= meas;
      sp_p0   <= setpoint;
      e_p1    <= EW'(sp_p0) - EW'(meas_p0);
      p_p2    <= PW'($signed({1'b0, kp})) * PW'(e_p1);
      i_p2    <= clear_int ? '0 : i_new;
      d_p2    <= (clear_int || !hist) ? '0 : d_raw;
   end

endmodule

// File: tb/tb_pid_core.sv
// Randomized and directed bench for pid_core against a cycle-scheduled arithmetic model.
module tb_pid_core;
   localparam int DATA_W = 16;
   localparam int GAIN_W = 16;
   localparam int FRAC_W = 8;
   localparam longint I_MAX = (longint'(1) << (DATA_W - 1 + FRAC_W)) - 1;
   localparam longint I_MIN = -(longint'(1) << (DATA_W - 1 + FRAC_W));
   localparam longint O_MAX = (longint'(1) << (DATA_W - 1)) - 1;
   localparam longint O_MIN = -(longint'(1) << (DATA_W - 1));

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              enable = 1'b0;
   logic              clear_int = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] meas = '0;
   logic [DATA_W-1:0] setpoint = '0;
   logic [GAIN_W-1:0] kp = '0;
   logic [GAIN_W-1:0] ki = '0;
   logic [GAIN_W-1:0] kd = '0;
   logic              out_valid;
   logic [DATA_W-1:0] ctrl_out;
   logic              sat_hi, sat_lo, int_clamped;

   pid_core #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .FRAC_W(FRAC_W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear_int(clear_int),
      .in_valid(in_valid), .meas(meas), .setpoint(setpoint),
      .kp(kp), .ki(ki), .kd(kd),
      .out_valid(out_valid), .ctrl_out(ctrl_out),
      .sat_hi(sat_hi), .sat_lo(sat_lo), .int_clamped(int_clamped)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   typedef struct { longint q; bit hi; bit lo; } res_t;

   longint m_i, m_eprev, m_q;
   bit     m_first, m_iclamp, m_hi, m_lo;
   longint samp[int];
   res_t   res[int];
   int     t = 0;
   longint obs_q[$];
   bit     obs_hi[$], obs_lo[$];
   int     obs_t[$];

   function automatic void model_clear_state();
      m_i = 0; m_eprev = 0; m_first = 1; m_iclamp = 0;
   endfunction

   function automatic void model_reset();
      model_clear_state();
      m_q = 0; m_hi = 0; m_lo = 0;
      samp.delete();
      res.delete();
   endfunction

   function automatic void obs_clear();
      obs_q.delete(); obs_hi.delete(); obs_lo.delete(); obs_t.delete();
   endfunction

   // One clock: advance the model with the inputs seen at this edge, then compare.
   task automatic step();
      bit exp_ov;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         model_reset();
      end else begin
         if (in_valid && enable)
            samp[t] = longint'($signed(setpoint)) - longint'($signed(meas));
         if (samp.exists(t - 2)) begin
            longint e, p, d, acc, inew, s;
            res_t r;
            e = samp[t - 2];
            samp.delete(t - 2);
            p = longint'(kp) * e;
            d = m_first ? 0 : longint'(kd) * (e - m_eprev);
            acc = m_i + longint'(ki) * e;
            inew = (acc > I_MAX) ? I_MAX : (acc < I_MIN) ? I_MIN : acc;
            if (clear_int) begin
               s = p;
               model_clear_state();
            end else begin
               s = p + inew + d;
               m_i = inew; m_eprev = e; m_first = 0; m_iclamp = (inew != acc);
            end
            r.q = s >>> FRAC_W;
            r.hi = (r.q > O_MAX);
            r.lo = (r.q < O_MIN);
            if (r.hi) r.q = O_MAX;
            if (r.lo) r.q = O_MIN;
            res[t + 1] = r;
         end else if (clear_int) begin
            model_clear_state();
         end
      end
      exp_ov = rst_n && res.exists(t);
      if (exp_ov) begin
         m_q = res[t].q; m_hi = res[t].hi; m_lo = res[t].lo;
         res.delete(t);
      end
      check("out_valid", out_valid, exp_ov);
      check("ctrl_out", $signed(ctrl_out), m_q);
      check("sat_hi", sat_hi, m_hi);
      check("sat_lo", sat_lo, m_lo);
      check("int_clamped", int_clamped, m_iclamp);
      if (out_valid === 1'b1) begin
         obs_q.push_back(longint'($signed(ctrl_out)));
         obs_hi.push_back(sat_hi);
         obs_lo.push_back(sat_lo);
         obs_t.push_back(t);
      end
      t++;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input int sp, input int m);
      setpoint = 16'(sp); meas = 16'(m); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_int = 1'b1;
      step();
      clear_int = 1'b0;
   endtask

   task automatic check_obs(input string tag, input int idx, input longint exp);
      if (idx < obs_q.size()) check(tag, obs_q[idx], exp);
      else check({tag, "_missing"}, obs_q.size(), idx + 1);
   endtask

   initial begin
      int t_acc;
      int vals[4];
      model_reset();
      #1 rst_n = 1'b0;
      idle(3);
      #3 rst_n = 1'b1;
      enable = 1'b1;

      // Proportional only, with latency
      kp = 16'd256; ki = '0; kd = '0;
      obs_clear();
      t_acc = t;
      send(1000, 400);
      idle(4);
      check("p_count", obs_q.size(), 1);
      if (obs_t.size() > 0) check("p_latency", obs_t[0] - t_acc, 3);
      check_obs("p_out", 0, 600);
      if (obs_hi.size() > 0) check("p_sat", {obs_hi[0], obs_lo[0]}, 0);

      // Output saturation both ways
      kp = 16'd512;
      obs_clear();
      send(32767, -32768);
      send(-32768, 32767);
      idle(4);
      check_obs("sat_pos", 0, 32767);
      check_obs("sat_neg", 1, -32768);
      if (obs_hi.size() > 1) begin
         check("sat_hi_flag", obs_hi[0], 1);
         check("sat_lo_flag", obs_lo[1], 1);
      end

      // Integrator ramp, windup, unwind
      pulse_clear();
      kp = '0; ki = 16'd128; kd = '0;
      obs_clear();
      setpoint = 16'd100; meas = '0; in_valid = 1'b1;
      idle(700);
      in_valid = 1'b0;
      idle(4);
      check("wind_count", obs_q.size(), 700);
      check_obs("wind_0", 0, 50);
      check_obs("wind_1", 1, 100);
      check_obs("wind_2", 2, 150);
      check_obs("wind_654", 654, 32750);
      check_obs("wind_655", 655, 32767);
      check_obs("wind_699", 699, 32767);
      check("wind_clamped", int_clamped, 1);
      obs_clear();
      send(0, 100);
      idle(4);
      check_obs("unwind", 0, 32717);
      check("unwind_clamped", int_clamped, 0);

      // Derivative and first-sample rule
      pulse_clear();
      kp = '0; ki = '0; kd = 16'd256;
      obs_clear();
      vals = '{0, 50, 50, 20};
      in_valid = 1'b1; meas = '0;
      foreach (vals[i]) begin
         setpoint = 16'(vals[i]);
         step();
      end
      in_valid = 1'b0;
      idle(4);
      check_obs("d_0", 0, 0);
      check_obs("d_1", 1, 50);
      check_obs("d_2", 2, 0);
      check_obs("d_3", 3, -30);
      pulse_clear();
      obs_clear();
      send(50, 0);
      idle(4);
      check_obs("d_first", 0, 0);

      // enable freeze holds the integrator
      pulse_clear();
      kp = '0; ki = 16'd256; kd = '0;
      send(10, 0);
      idle(4);
      obs_clear();
      enable = 1'b0; in_valid = 1'b1; setpoint = 16'd1000; meas = '0;
      idle(5);
      in_valid = 1'b0; enable = 1'b1;
      idle(3);
      check("frz_count", obs_q.size(), 0);
      ki = '0;
      send(0, 0);
      idle(4);
      check_obs("frz_hold", 0, 10);

      // clear_int while the sample is in the term stage
      kp = 16'd256; ki = 16'd256; kd = 16'd256;
      obs_clear();
      send(100, 0);
      step();
      pulse_clear();
      idle(2);
      check_obs("clr_s2", 0, 100);
      obs_clear();
      send(100, 0);
      idle(4);
      check_obs("clr_after", 0, 200);

      // Random stream
      for (int n = 0; n < 1500; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         enable    = ($urandom_range(0, 7) != 0);
         clear_int = ($urandom_range(0, 31) == 0);
         setpoint  = 16'($urandom);
         meas      = 16'($urandom);
         if (n % 600 < 300) begin
            setpoint = 16'($signed(16'($urandom_range(0, 400))) - 200);
            meas     = 16'($signed(16'($urandom_range(0, 400))) - 200);
            kp = 16'($urandom_range(0, 1023));
            ki = 16'($urandom_range(0, 511));
            kd = 16'($urandom_range(0, 1023));
         end else begin
            kp = 16'($urandom);
            ki = 16'($urandom);
            kd = 16'($urandom);
         end
         step();
      end
      clear_int = 1'b0; enable = 1'b1;

      // Async reset with three samples in flight
      in_valid = 1'b1;
      idle(3);
      in_valid = 1'b0;
      obs_clear();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_ov", out_valid, 0);
      check("arst_out", $signed(ctrl_out), 0);
      check("arst_flags", {sat_hi, sat_lo, int_clamped}, 0);
      idle(3);
      #3 rst_n = 1'b1;
      idle(2);
      check("arst_none", obs_q.size(), 0);
      kp = 16'd256; ki = 16'd256; kd = 16'd256;
      send(10, 0);
      idle(4);
      check_obs("arst_first", 0, 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
